// File: rtl/avg_result_checker_if.sv
// Result stream from avg plus the expected-value memory read port.
// Handshake: a result is transferred on every rising clk edge where
// ready=1; dout is valid only then. There is no backpressure.
// exp_addr is the checker's read address; exp_data must return
// mem[exp_addr] combinationally within the same cycle.
// master: the environment side (avg and the expected-value memory).
// slave:  the checker.
interface avg_result_checker_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic          ready;
  logic [DW-1:0] dout;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  modport master (
    output ready,
    output dout,
    output exp_data,
    input  exp_addr
  );

  modport slave (
    input  ready,
    input  dout,
    input  exp_data,
    output exp_addr
  );
endinterface

// File: rtl/avg_result_checker.sv
// Golden-vector checker for the avg result stream. Counts accepted
// results, compares each against the expected memory, counts mismatches
// (saturating), records the first mismatch index, and reports done/pass
// or an idle-watchdog timeout.
module avg_result_checker #(
  parameter int DW      = 16,
  parameter int AW      = 12,
  parameter int N_RES   = 1988,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  avg_result_checker_if.slave  res,
  output logic [AW-1:0]        res_cnt,
  output logic [AW-1:0]        err_cnt,
  output logic [AW-1:0]        first_err_idx,
  output logic                 first_err_vld,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [1:0]           dbg_state
);

  // Idle counter only needs to reach TIMEOUT-1 before the watchdog fires.
  localparam int             IW        = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]  LAST_IDX  = AW'(N_RES - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [AW-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_TOUT = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic          mismatch;
  logic [AW-1:0] err_inc;

  // Case-inequality so any X/Z bit in simulation is treated as a mismatch.
  assign mismatch = (res.dout !== res.exp_data);

  // Saturating increment of the mismatch counter.
  assign err_inc = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + AW'(1);

  // The memory is always addressed by the index of the next result.
  assign res.exp_addr = res_cnt;
  assign dbg_state    = state;

  // Run-control FSM with all counters and status flags registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      idle_cnt      <= '0;
      res_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      case (state)
        // Outside RUN, ready is ignored; start wins even if ready is high.
        S_IDLE, S_DONE, S_TOUT: begin
          if (start) begin
            state         <= S_RUN;
            idle_cnt      <= '0;
            res_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
          end
        end

        S_RUN: begin
          if (res.ready) begin
            res_cnt  <= res_cnt + AW'(1);
            idle_cnt <= '0;
            if (mismatch) begin
              err_cnt <= err_inc;
              if (!first_err_vld) begin
                first_err_idx <= res_cnt;
                first_err_vld <= 1'b1;
              end
            end
            // Final result: finish on this same edge, folding in its compare.
            if (res_cnt == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (err_cnt == '0) && !mismatch;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state   <= S_TOUT;
            timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_result_checker.sv
// Bench for avg_result_checker: two instances (N_RES=8/TIMEOUT=4 with AW=12,
// and AW=3/N_RES=7 with the default TIMEOUT) driven by directed sequences,
// a run-level reference model per instance, a per-cycle compare process and
// literal expectations for the documented scenarios.
module tb_avg_result_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_a, st_a, rdy_a;
  logic [15:0] dout_a;
  logic        rst_b, st_b, rdy_b;
  logic [15:0] dout_b;

  logic [15:0] mem_a [0:4095];
  logic [15:0] mem_b [0:7];

  avg_result_checker_if #(.DW(16), .AW(12)) if_a ();
  avg_result_checker_if #(.DW(16), .AW(3))  if_b ();

  assign if_a.ready    = rdy_a;
  assign if_a.dout     = dout_a;
  assign if_a.exp_data = mem_a[if_a.exp_addr];
  assign if_b.ready    = rdy_b;
  assign if_b.dout     = dout_b;
  assign if_b.exp_data = mem_b[if_b.exp_addr];

  logic [11:0] res_cnt_a, err_cnt_a, fidx_a;
  logic        fvld_a, done_a, pass_a, tout_a;
  logic [1:0]  dbg_a;
  logic [2:0]  res_cnt_b, err_cnt_b, fidx_b;
  logic        fvld_b, done_b, pass_b, tout_b;
  logic [1:0]  dbg_b;

  avg_result_checker #(.DW(16), .AW(12), .N_RES(8), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(rst_a), .start(st_a), .res(if_a.slave),
    .res_cnt(res_cnt_a), .err_cnt(err_cnt_a), .first_err_idx(fidx_a),
    .first_err_vld(fvld_a), .done(done_a), .pass(pass_a),
    .timeout(tout_a), .dbg_state(dbg_a)
  );

  avg_result_checker #(.DW(16), .AW(3), .N_RES(7)) dut_b (
    .clk(clk), .reset(rst_b), .start(st_b), .res(if_b.slave),
    .res_cnt(res_cnt_b), .err_cnt(err_cnt_b), .first_err_idx(fidx_b),
    .first_err_vld(fvld_b), .done(done_b), .pass(pass_b),
    .timeout(tout_b), .dbg_state(dbg_b)
  );

  // ---------------- reference model (run level) ----------------
  int n_res [2] = '{8, 7};
  int tmo   [2] = '{4, 64};
  int sat   [2] = '{4095, 7};

  bit m_run   [2] = '{0, 0};
  bit m_fin   [2] = '{0, 0};
  bit m_exp   [2] = '{0, 0};
  int m_acc   [2] = '{0, 0};
  int m_gap   [2] = '{0, 0};
  int m_mm    [2] = '{0, 0};
  int m_first [2] = '{-1, -1};

  task automatic model_clear(input int k);
    m_run[k] = 0; m_fin[k] = 0; m_exp[k] = 0;
    m_acc[k] = 0; m_gap[k] = 0; m_mm[k] = 0; m_first[k] = -1;
  endtask

  task automatic model_step(input int k, input bit st, input bit rdy,
                            input logic [15:0] d, input logic [15:0] golden);
    if (!m_run[k]) begin
      if (st) begin
        model_clear(k);
        m_run[k] = 1;
      end
    end else if (rdy) begin
      if (d !== golden) begin
        if (m_first[k] < 0) m_first[k] = m_acc[k];
        m_mm[k]++;
      end
      m_acc[k]++;
      m_gap[k] = 0;
      if (m_acc[k] == n_res[k]) begin
        m_fin[k] = 1;
        m_run[k] = 0;
      end
    end else begin
      m_gap[k]++;
      if (m_gap[k] == tmo[k]) begin
        m_exp[k] = 1;
        m_run[k] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst_a);
    if (rst_a) model_clear(0);
    else       model_step(0, st_a, rdy_a, dout_a, mem_a[m_acc[0]]);
  end

  initial forever begin
    @(posedge clk or posedge rst_b);
    if (rst_b) model_clear(1);
    else       model_step(1, st_b, rdy_b, dout_b, mem_b[m_acc[1] % 8]);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input int k, input logic [31:0] addr,
                         input logic [31:0] rc, input logic [31:0] ec,
                         input logic [31:0] fi, input logic fv,
                         input logic dn, input logic ps, input logic to,
                         input logic [1:0] st);
    string p;
    int    e_ec;
    int    e_st;
    p    = (k == 0) ? "a" : "b";
    e_ec = (m_mm[k] > sat[k]) ? sat[k] : m_mm[k];
    e_st = m_run[k] ? 1 : m_fin[k] ? 2 : m_exp[k] ? 3 : 0;
    chk({p, ".exp_addr"},      addr, 32'(m_acc[k]));
    chk({p, ".res_cnt"},       rc,   32'(m_acc[k]));
    chk({p, ".err_cnt"},       ec,   32'(e_ec));
    chk({p, ".first_err_idx"}, fi,   (m_first[k] < 0) ? 32'd0 : 32'(m_first[k]));
    chk({p, ".first_err_vld"}, 32'(fv), 32'(m_first[k] >= 0));
    chk({p, ".done"},          32'(dn), 32'(m_fin[k]));
    chk({p, ".pass"},          32'(ps), 32'(m_fin[k] && m_mm[k] == 0));
    chk({p, ".timeout"},       32'(to), 32'(m_exp[k]));
    chk({p, ".state"},         32'(st), 32'(e_st));
  endtask

  initial forever begin
    @(negedge clk);
    compare(0, 32'(if_a.exp_addr), 32'(res_cnt_a), 32'(err_cnt_a),
            32'(fidx_a), fvld_a, done_a, pass_a, tout_a, dbg_a);
    compare(1, 32'(if_b.exp_addr), 32'(res_cnt_b), 32'(err_cnt_b),
            32'(fidx_b), fvld_b, done_b, pass_b, tout_b, dbg_b);
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns 1 time unit after the next one.
  task automatic cyc_a(input bit st, input bit rdy, input logic [15:0] d);
    st_a = st; rdy_a = rdy; dout_a = d;
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic cyc_b(input bit st, input bit rdy, input logic [15:0] d);
    st_b = st; rdy_b = rdy; dout_b = d;
    @(posedge clk); @(negedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_a = 1'b1; st_a = 1'b0; rdy_a = 1'b0; dout_a = '0;
    rst_b = 1'b1; st_b = 1'b0; rdy_b = 1'b0; dout_b = '0;
    for (int i = 0; i < 4096; i++) mem_a[i] = 16'(i);
    for (int i = 0; i < 8; i++)    mem_b[i] = 16'(i * 3 + 1);

    repeat (2) @(negedge clk);
    #1;
    chk("reset res_cnt", 32'(res_cnt_a), 32'd0);
    chk("reset done",    32'(done_a),    32'd0);
    chk("reset timeout", 32'(tout_a),    32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    cyc_a(0, 1, 16'h0);                     // ready in IDLE is ignored
    chk("idle ready ignored", 32'(res_cnt_a), 32'd0);

    // 8 matching results back to back
    cyc_a(1, 0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      cyc_a(0, 1, 16'(i));
      if (i == 6) chk("t1 done before last", 32'(done_a), 32'd0);
    end
    cyc_a(0, 0, 16'h0);
    chk("t1 res_cnt", 32'(res_cnt_a), 32'd8);
    chk("t1 err_cnt", 32'(err_cnt_a), 32'd0);
    chk("t1 done",    32'(done_a),    32'd1);
    chk("t1 pass",    32'(pass_a),    32'd1);
    chk("t1 fvld",    32'(fvld_a),    32'd0);

    // restart from DONE with ready high: only start is taken
    cyc_a(1, 1, 16'h5555);
    chk("t2 start+ready res_cnt", 32'(res_cnt_a), 32'd0);
    chk("t2 done cleared",        32'(done_a),    32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc_a(0, 1, (i == 3) ? 16'h1234 : (i == 6) ? 16'hbeef : 16'(i));
      if (i == 3) chk("t2 first idx early", 32'(fidx_a), 32'd3);
    end
    cyc_a(0, 0, 16'h0);
    chk("t2 err_cnt", 32'(err_cnt_a), 32'd2);
    chk("t2 fidx",    32'(fidx_a),    32'd3);
    chk("t2 fvld",    32'(fvld_a),    32'd1);
    chk("t2 done",    32'(done_a),    32'd1);
    chk("t2 pass",    32'(pass_a),    32'd0);

    // watchdog: 2 results, then ready low
    cyc_a(1, 0, 16'h0);
    cyc_a(0, 1, 16'd0);
    cyc_a(0, 1, 16'd1);
    repeat (3) cyc_a(0, 0, 16'h0);
    chk("t3 no timeout at 3", 32'(tout_a), 32'd0);
    cyc_a(0, 0, 16'h0);
    chk("t3 timeout at 4", 32'(tout_a),    32'd1);
    chk("t3 res_cnt",      32'(res_cnt_a), 32'd2);
    chk("t3 done",         32'(done_a),    32'd0);
    cyc_a(0, 1, 16'd2);
    chk("t3 frozen", 32'(res_cnt_a), 32'd2);
    cyc_a(1, 0, 16'h0);
    chk("t3 restart timeout", 32'(tout_a),    32'd0);
    chk("t3 restart res_cnt", 32'(res_cnt_a), 32'd0);

    // gapped ready (1 on, 3 off) with a start pulse mid-run
    for (int i = 0; i < 8; i++) begin
      cyc_a(0, 1, 16'(i));
      cyc_a(i == 4, 0, 16'h0);
      if (i == 4) chk("t4 start ignored", 32'(res_cnt_a), 32'd5);
      cyc_a(0, 0, 16'h0);
      cyc_a(0, 0, 16'h0);
    end
    chk("t4 timeout", 32'(tout_a),    32'd0);
    chk("t4 done",    32'(done_a),    32'd1);
    chk("t4 pass",    32'(pass_a),    32'd1);
    chk("t4 res_cnt", 32'(res_cnt_a), 32'd8);

    // asynchronous reset after 5 of 8 results
    cyc_a(1, 0, 16'h0);
    for (int i = 0; i < 5; i++) cyc_a(0, 1, 16'(i));
    rdy_a = 1'b0;
    #2 rst_a = 1'b1;
    #1;
    chk("t5 async res_cnt", 32'(res_cnt_a), 32'd0);
    chk("t5 async state",   32'(dbg_a),     32'd0);
    @(negedge clk); #1;
    rst_a = 1'b0;
    cyc_a(0, 1, 16'd0);
    cyc_a(0, 1, 16'd1);
    chk("t5 ready before start", 32'(res_cnt_a), 32'd0);
    cyc_a(1, 0, 16'h0);
    for (int i = 0; i < 8; i++) cyc_a(0, 1, 16'(i));
    chk("t5 rerun pass", 32'(pass_a), 32'd1);
    cyc_a(0, 0, 16'h0);

    // AW=3, N_RES=7, every result mismatches
    cyc_b(1, 0, 16'h0);
    for (int i = 0; i < 7; i++) begin
      cyc_b(0, 1, (i == 4) ? ~mem_b[i] : (mem_b[i] ^ 16'h8000));
      if (i == 0) chk("t6 err after first", 32'(err_cnt_b), 32'd1);
    end
    cyc_b(0, 0, 16'h0);
    chk("t6 err_cnt", 32'(err_cnt_b), 32'd7);
    chk("t6 res_cnt", 32'(res_cnt_b), 32'd7);
    chk("t6 done",    32'(done_b),    32'd1);
    chk("t6 pass",    32'(pass_b),    32'd0);
    chk("t6 fidx",    32'(fidx_b),    32'd0);
    chk("t6 fvld",    32'(fvld_b),    32'd1);

    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_result_checker.md
# avg_result_checker

Synthesizable sink for the 16-bit `avg` result stream: it consumes `ready`/`dout`, fetches the golden value for each result from an external expected-value memory, and compares the two. It keeps result and mismatch counts, records the index of the first mismatch, and reports done, pass, or timeout. It replaces the simulation-only checker so that the same golden-vector check can run on silicon or FPGA next to `avg`.

## Interface
- `DW`, 16, data width of `dout` and `exp_data`
- `AW`, 12, width of the expected-memory address and of all counters
- `N_RES`, 1988, number of results expected per run (1 .. 2^AW-1)
- `TIMEOUT`, 64, maximum consecutive RUN cycles without `ready` (>= 2)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a run
- `ready`  in  1  result-valid strobe from `avg`
- `dout`  in  DW  result data from `avg`, valid when `ready`=1
- `exp_addr`  out  AW  expected-memory read address; always equals `res_cnt`
- `exp_data`  in  DW  expected value at `exp_addr`; combinational (zero-latency) read
- `res_cnt`  out  AW  number of results accepted in the current run
- `err_cnt`  out  AW  number of mismatches; saturates at all-ones
- `first_err_idx`  out  AW  index of the first mismatch
- `first_err_vld`  out  1  `first_err_idx` holds a valid index
- `done`  out  1  N_RES results have been accepted
- `pass`  out  1  `done` and `err_cnt`==0
- `timeout`  out  1  the idle watchdog has expired

## Operation
- States: IDLE, RUN, DONE, TOUT. Reset enters IDLE.
- All outputs are registered. Reset value of every output is 0.
- IDLE:
  - `ready` is ignored.
  - `start`=1 → RUN. On that edge, clear `res_cnt`, `err_cnt`, `first_err_*`, and the idle counter.
- RUN:
  - Each edge with `ready`=1 accepts one result: `res_cnt` += 1 and the idle counter is cleared.
  - `dout !== exp_data` is a mismatch. Compare all DW bits; any X or Z counts as a mismatch in simulation.
  - On a mismatch, `err_cnt` increments, saturating at 2^AW-1.
  - If `first_err_vld`=0 on a mismatch, latch `first_err_idx` = current `res_cnt` and set `first_err_vld`.
  - Each edge with `ready`=0 increments the idle counter.
  - Acceptance that makes `res_cnt` == N_RES → DONE on the same edge. `done` = 1 and `pass` = (final `err_cnt` == 0).
  - Idle counter reaching TIMEOUT with `ready`=0 → TOUT and `timeout` = 1. Counters are frozen.
  - `start` is ignored in RUN.
- DONE and TOUT:
  - `ready` is ignored and all counters hold.
  - `start`=1 → RUN with counters cleared. `done`, `pass`, and `timeout` clear on the same edge.
- If `start` and `ready` are both high on the edge that leaves IDLE/DONE/TOUT, only `start` is taken. That `ready` is not accepted.
- Asynchronous `reset` mid-run returns the block to IDLE immediately with all outputs at 0. The partial run is discarded.

## Timing
- `exp_addr` changes only on clock edges. `exp_data` must settle within the same cycle.
- The accept/compare decision uses `ready`, `dout`, and `exp_data` sampled at the rising edge. Updated counters are visible one edge later (1-cycle latency).
- `done`/`pass` rise on the edge that accepts result N_RES-1 (0-based), with no extra cycle.
- `timeout` rises on the TIMEOUT-th consecutive idle edge after entering RUN or after the last accept.
- Back-to-back `ready` every cycle is supported with no stall. There is no backpressure to `avg`.

## Test plan
- Reset, then `start`, then N_RES=8 results matching `exp_data` (0,1,…,7), one per cycle → `res_cnt`=8, `err_cnt`=0, `done`=1 and `pass`=1 on the 8th accept edge, `first_err_vld`=0.
- Same as above but result 3 = 16'h1234 against expected 16'h0003, and result 6 also mismatches → `err_cnt`=2, `first_err_idx`=3, `first_err_vld`=1, `done`=1, `pass`=0.
- TIMEOUT=4: `start`, 2 results, then `ready` held low → `timeout`=1 on the 4th idle edge, `res_cnt`=2, `done`=0. A new `start` clears everything and re-enters RUN.
- Gapped `ready` (1 cycle on, 3 off) with TIMEOUT=4 → no timeout, and each result compared against the correct `exp_addr`. Also `start` pulsed mid-RUN → ignored, counts unaffected.
- Assert `reset` asynchronously (between edges) after 5 of 8 results → all outputs 0 immediately. `ready` pulses before the next `start` do not count.
- AW=3, N_RES=7, all 7 results mismatch → `err_cnt`=7 (saturated), `done`=1, `pass`=0.
